lc3_mio_bus_ctl: RTL and testbench

Parametrised memory/IO bus controller for the LC-3 core, sitting between the CPU memory interface and the memory-mapped device registers (KBSR/KBDR/DSR/DDR and further channels). Latches each access at its start, decodes it to main memory or one of `NUM_DEV` device channels, and drives per-channel load and read strobes plus the read-data select. Terminates each access with a single-cycle ready pulse after a per-target programmable wait count.

---
 rtl/lc3_mio_bus_ctl_pkg.sv | 21 ++
 rtl/lc3_mio_bus_ctl_if.sv | 32 +++
 rtl/lc3_mio_bus_ctl_decode.sv | 29 ++
 rtl/lc3_mio_bus_ctl.sv | 112 +++++++++++
 tb/tb_lc3_mio_bus_ctl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lc3_mio_bus_ctl_pkg.sv
// Shared types and constants for the LC-3 memory/IO bus controller.
// Optional read-only write error reporting is enabled with LC3_MIO_RO_ERR_EN.
package lc3_mio_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      HOLD
   } state_e;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;

   // Width of the read-data select: device channels plus one memory code.
   function automatic int sel_width(input int num_dev);
      return $clog2(num_dev + 1);
   endfunction

endpackage

// File: rtl/lc3_mio_bus_ctl_if.sv
// CPU-side memory/IO bus between the LC-3 core and the bus controller.
// The master modport is the CPU, the slave modport is lc3_mio_bus_ctl.
interface lc3_mio_bus_ctl_if
   import lc3_mio_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int NUM_DEV = 4
);
   localparam int SEL_W = sel_width(NUM_DEV);

   logic [ADDR_W-1:0]  addr;
   logic               mio_en;
   logic               r_w;
   logic [SEL_W-1:0]   inmux;
   logic               mem_en;
   logic [NUM_DEV-1:0] dev_ld;
   logic [NUM_DEV-1:0] dev_rd;
   logic               r;
   logic               busy;
   logic               err;

   modport master (
      output addr, mio_en, r_w,
      input  inmux, mem_en, dev_ld, dev_rd, r, busy, err
   );

   modport slave (
      input  addr, mio_en, r_w,
      output inmux, mem_en, dev_ld, dev_rd, r, busy, err
   );

endinterface

// File: rtl/lc3_mio_bus_ctl_decode.sv
// Combinational address decoder: device channel hit and index, or memory.
// The index output carries NUM_DEV when the address does not hit a channel.
module lc3_mio_decode
   import lc3_mio_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter int                NUM_DEV    = 4,
   parameter logic [ADDR_W-1:0] DEV_BASE   = ADDR_W'(ADDR_KBSR),
   parameter int                DEV_STRIDE = 2
) (
   input  logic [ADDR_W-1:0]              addr_i,
   output logic                           is_dev_o,
   output logic [sel_width(NUM_DEV)-1:0]  idx_o
);
   localparam int                SEL_W      = sel_width(NUM_DEV);
   localparam logic [ADDR_W-1:0] WIN        = ADDR_W'(NUM_DEV * DEV_STRIDE);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DEV_STRIDE - 1);
   localparam int                SHIFT      = $clog2(DEV_STRIDE);

   logic [ADDR_W-1:0] off;

   // The lower-bound compare keeps addresses below the base from wrapping into the window.
   always_comb begin
      off      = addr_i - DEV_BASE;
      is_dev_o = (addr_i >= DEV_BASE) && (off < WIN) && ((off & ALIGN_MASK) == '0);
      idx_o    = is_dev_o ? SEL_W'(off >> SHIFT) : SEL_W'(NUM_DEV);
   end

endmodule

// File: rtl/lc3_mio_bus_ctl.sv
// LC-3 memory/IO bus controller: latches an access, waits the target latency, pulses r.
// Define LC3_MIO_RO_ERR_EN to flag writes to read-only channels on err.
module lc3_mio_bus_ctl
   import lc3_mio_pkg::*;
#(
   parameter int                 ADDR_W      = 16,
   parameter int                 NUM_DEV     = 4,
   parameter logic [ADDR_W-1:0]  DEV_BASE    = ADDR_W'(ADDR_KBSR),
   parameter int                 DEV_STRIDE  = 2,
   parameter logic [NUM_DEV-1:0] DEV_RO_MASK = NUM_DEV'(4'b0010),
   parameter int                 MEM_LAT     = 15,
   parameter int                 DEV_LAT     = 1
) (
   input logic              clk,
   input logic              rst_n,
   lc3_mio_bus_ctl_if.slave bus
);
   localparam int               SEL_W    = sel_width(NUM_DEV);
   localparam logic [SEL_W-1:0] SEL_MEM  = SEL_W'(NUM_DEV);
   localparam logic [7:0]       MEM_CNT0 = 8'(MEM_LAT - 1);
   localparam logic [7:0]       DEV_CNT0 = 8'(DEV_LAT - 1);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [SEL_W-1:0]   tgt_q, tgt_d;
   logic               is_dev_q, is_dev_d;
   logic               wr_q, wr_d;
   logic               dec_is_dev;
   logic [SEL_W-1:0]   dec_idx;
   logic [NUM_DEV-1:0] dev_oh;

   lc3_mio_decode #(
      .ADDR_W     (ADDR_W),
      .NUM_DEV    (NUM_DEV),
      .DEV_BASE   (DEV_BASE),
      .DEV_STRIDE (DEV_STRIDE)
   ) u_decode (
      .addr_i   (bus.addr),
      .is_dev_o (dec_is_dev),
      .idx_o    (dec_idx)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tgt_q    <= SEL_MEM;
         is_dev_q <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tgt_q    <= tgt_d;
         is_dev_q <= is_dev_d;
         wr_q     <= wr_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      is_dev_d   = is_dev_q;
      wr_d       = wr_q;
      bus.r      = 1'b0;
      bus.mem_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.mio_en) begin
               tgt_d    = dec_idx;
               is_dev_d = dec_is_dev;
               wr_d     = bus.r_w;
               cnt_d    = dec_is_dev ? DEV_CNT0 : MEM_CNT0;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!bus.mio_en) begin
               state_d = IDLE;
            end else begin
               bus.mem_en = !is_dev_q;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  bus.r   = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (!bus.mio_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes depend only on registered target and the r term, never on live addr.
   assign dev_oh      = is_dev_q ? (NUM_DEV'(1) << tgt_q) : '0;
   assign bus.dev_ld  = (bus.r && wr_q)  ? (dev_oh & ~DEV_RO_MASK) : '0;
   assign bus.dev_rd  = (bus.r && !wr_q) ? dev_oh : '0;
   assign bus.inmux   = (state_q == IDLE) ? SEL_MEM : tgt_q;
   assign bus.busy    = (state_q != IDLE);

`ifdef LC3_MIO_RO_ERR_EN
   assign bus.err = bus.r && wr_q && |(dev_oh & DEV_RO_MASK);
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mio_bus_ctl.sv
// Scoreboard bench for lc3_mio_bus_ctl: default 4-channel build plus a 6-channel build.
`timescale 1ns/1ps
module tb_lc3_mio_bus_ctl;
   import lc3_mio_pkg::*;

   typedef struct {
      string tag;
      int    n_r;
      int    r_cyc;
      int    inmux;
      int    ld;
      int    rd;
      int    err;
      int    mem_cnt;
      int    busy_cnt;
   } exp_t;

`ifdef LC3_MIO_RO_ERR_EN
   localparam int RO_ERR = 1;
`else
   localparam int RO_ERR = 0;
`endif

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [15:0] addr   = 16'h0000;
   logic        mio_en = 1'b0;
   logic        r_w    = 1'b0;
   bit          sel6   = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   lc3_mio_bus_ctl_if #(.ADDR_W(16), .NUM_DEV(4)) bus4 ();
   lc3_mio_bus_ctl_if #(.ADDR_W(16), .NUM_DEV(6)) bus6 ();

   assign bus4.addr   = addr;
   assign bus4.mio_en = mio_en;
   assign bus4.r_w    = r_w;
   assign bus6.addr   = addr;
   assign bus6.mio_en = mio_en;
   assign bus6.r_w    = r_w;

   lc3_mio_bus_ctl dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   lc3_mio_bus_ctl #(.NUM_DEV(6), .DEV_RO_MASK(6'b000010)) dut6 (
      .clk(clk), .rst_n(rst_n), .bus(bus6)
   );

   always #5 clk = ~clk;

   logic [2:0] m_inmux;
   logic [7:0] m_ld, m_rd;
   logic       m_r, m_err, m_mem, m_busy;

   always_comb begin
      if (sel6) begin
         m_inmux = bus6.inmux;
         m_ld    = 8'(bus6.dev_ld);
         m_rd    = 8'(bus6.dev_rd);
         m_r     = bus6.r;
         m_err   = bus6.err;
         m_mem   = bus6.mem_en;
         m_busy  = bus6.busy;
      end else begin
         m_inmux = bus4.inmux;
         m_ld    = 8'(bus4.dev_ld);
         m_rd    = 8'(bus4.dev_rd);
         m_r     = bus4.r;
         m_err   = bus4.err;
         m_mem   = bus4.mem_en;
         m_busy  = bus4.busy;
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic exp_t mk(input string tag, input int n_r, input int r_cyc, input int inmux,
                               input int ld, input int rd, input int err,
                               input int mem_cnt, input int busy_cnt);
      exp_t e;
      e.tag = tag; e.n_r = n_r; e.r_cyc = r_cyc; e.inmux = inmux; e.ld = ld;
      e.rd = rd; e.err = err; e.mem_cnt = mem_cnt; e.busy_cnt = busy_cnt;
      return e;
   endfunction

   // Monitor: follows one access from cycle 0 to the return to IDLE, then scores it.
   bit act = 1'b0;
   int cyc, n_r, r_cyc, r_inmux, r_ld, r_rd, r_err, mem_cnt, busy_cnt, stray;

   always @(negedge clk) begin
      if (!act) begin
         if (rst_n && !m_busy && mio_en) begin
            act = 1'b1; cyc = 0; n_r = 0; r_cyc = -1; r_inmux = -1;
            r_ld = 0; r_rd = 0; r_err = 0; mem_cnt = 0; busy_cnt = 0; stray = 0;
         end
      end else begin
         cyc++;
         if (!m_busy) begin
            exp_t e;
            act = 1'b0;
            check("exp_available", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({e.tag, ".n_r"},      n_r,      e.n_r);
               check({e.tag, ".r_cyc"},    r_cyc,    e.r_cyc);
               check({e.tag, ".inmux"},    r_inmux,  e.inmux);
               check({e.tag, ".dev_ld"},   r_ld,     e.ld);
               check({e.tag, ".dev_rd"},   r_rd,     e.rd);
               check({e.tag, ".err"},      r_err,    e.err);
               check({e.tag, ".mem_cnt"},  mem_cnt,  e.mem_cnt);
               check({e.tag, ".busy_cnt"}, busy_cnt, e.busy_cnt);
               check({e.tag, ".stray"},    stray,    0);
               check({e.tag, ".idle_inmux"}, int'(m_inmux), sel6 ? 6 : 4);
               check({e.tag, ".idle_outs"},
                     int'({m_r, m_err, m_mem, |m_ld, |m_rd}), 0);
            end
         end else begin
            busy_cnt++;
            if (m_mem) mem_cnt++;
            if (m_r) begin
               n_r++; r_cyc = cyc; r_inmux = int'(m_inmux);
               r_ld = int'(m_ld); r_rd = int'(m_rd); r_err = int'(m_err);
            end else if (m_err || (m_ld != 0) || (m_rd != 0)) begin
               stray++;
            end
         end
      end
   end

   // Drives one access: mio_en high in cycles 0..n_hold-1; addr and r_w disturbed in cycle 1.
   task automatic access(input bit s6, input logic [15:0] a, input logic w,
                         input logic [15:0] alt, input int n_hold, input int rst_cyc,
                         input exp_t e);
      sel6 = s6;
      exp_q.push_back(e);
      @(posedge clk); #1;
      addr = a; r_w = w; mio_en = 1'b1;
      for (int c = 1; c <= n_hold; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            addr = alt;
            r_w  = ~w;
         end
         rst_n = (c == rst_cyc) ? 1'b0 : 1'b1;
         if (c >= n_hold) mio_en = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset.inmux4", int'(bus4.inmux), 4);
      check("reset.inmux6", int'(bus6.inmux), 6);
      check("reset.outs", int'({bus4.busy, bus4.r, bus4.err, bus4.mem_en,
                                |bus4.dev_ld, |bus4.dev_rd}), 0);

      //       sel a         w     alt       hold rst  tag          n_r cyc mux ld    rd    err     mem busy
      access(0, ADDR_KBDR, 1'b0, ADDR_KBDR,  4, -1, mk("rd_fe02",    1,  1, 1, 0,    'h2,  0,       0,  4));
      access(0, 16'h3000,  1'b1, 16'h3002,  18, -1, mk("wr_3000",    1, 15, 4, 0,    0,    0,      15, 18));
      access(0, ADDR_DSR,  1'b1, ADDR_DDR,   3, -1, mk("wr_fe04",    1,  1, 2, 'h4,  0,    0,       0,  3));
      access(0, ADDR_KBDR, 1'b1, ADDR_KBDR,  2, -1, mk("wr_fe02_ro", 1,  1, 1, 0,    0,    RO_ERR,  0,  2));
      access(0, 16'h3000,  1'b0, 16'h3000,   5, -1, mk("abort",      0, -1,-1, 0,    0,    0,       4,  5));
      access(0, 16'h3000,  1'b0, 16'h3000,   6,  5, mk("rst_mid",    0, -1,-1, 0,    0,    0,       5,  5));
      access(0, 16'hFE01,  1'b0, ADDR_KBSR, 17, -1, mk("rd_fe01",    1, 15, 4, 0,    0,    0,      15, 17));
      access(0, 16'hFE08,  1'b1, ADDR_DDR,  16, -1, mk("wr_fe08",    1, 15, 4, 0,    0,    0,      15, 16));
      access(0, ADDR_DDR,  1'b0, ADDR_KBSR,  2, -1, mk("rd_fe06",    1,  1, 3, 0,    'h8,  0,       0,  2));
      access(0, ADDR_KBSR, 1'b1, ADDR_DSR,   2, -1, mk("wr_fe00",    1,  1, 0, 'h1,  0,    0,       0,  2));
      access(0, 16'hFDFE,  1'b0, ADDR_KBSR, 16, -1, mk("rd_fdfe",    1, 15, 4, 0,    0,    0,      15, 16));
      access(0, 16'hFFFE,  1'b0, ADDR_KBSR, 16, -1, mk("rd_fffe",    1, 15, 4, 0,    0,    0,      15, 16));
      access(1, 16'hFE0A,  1'b0, ADDR_KBSR,  2, -1, mk("d6_rd_fe0a", 1,  1, 5, 0,    'h20, 0,       0,  2));
      access(1, 16'hFE08,  1'b1, ADDR_KBSR,  2, -1, mk("d6_wr_fe08", 1,  1, 4, 'h10, 0,    0,       0,  2));
      access(1, 16'hFE0C,  1'b0, 16'hFE0A,  16, -1, mk("d6_rd_fe0c", 1, 15, 6, 0,    0,    0,      15, 16));

      repeat (5) @(posedge clk);
      check("pending_expectations", exp_q.size(), 0);
      check("monitor_idle", int'(act), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
